// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM stage: FSM states, byte-enable codes
// and the store lane-replication helper.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT_R = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  // link_rw_ level meaning "no SC result write"
  localparam logic READ_MODE = 1'b1;

  function automatic logic [31:0] store_replicate(input logic [31:0] wdata,
                                                  input logic [3:0]  be);
    logic [31:0] rep;
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3: rep = {4{wdata[7:0]}};
      BE_H0, BE_H1:               rep = {2{wdata[15:0]}};
      default:                    rep = wdata;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/gnt/rvalid bus between the MEM stage and the data memory.
interface mem_access_stage_if #(parameter int BITS = 32);

  logic            d_mem_req;
  logic            d_mem_we;
  logic [BITS-1:0] d_mem_addr;
  logic [BITS-1:0] d_mem_wdata;
  logic [3:0]      d_mem_be;
  logic            d_mem_gnt;
  logic            d_mem_rvalid;
  logic [BITS-1:0] d_mem_rdata_raw;

  modport master (
    output d_mem_req, d_mem_we, d_mem_addr, d_mem_wdata, d_mem_be,
    input  d_mem_gnt, d_mem_rvalid, d_mem_rdata_raw
  );

  modport slave (
    input  d_mem_req, d_mem_we, d_mem_addr, d_mem_wdata, d_mem_be,
    output d_mem_gnt, d_mem_rvalid, d_mem_rdata_raw
  );

endinterface

// File: rtl/mem_access_stage_load_align.sv
// Selects the addressed byte/half lane of a raw memory word and extends it.
module load_align
  import mem_stage_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic [BITS-1:0] raw,
  input  logic [3:0]      byte_en,
  input  logic            load_signed,
  output logic [BITS-1:0] aligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [1:0]  kind_s;  // 0 = word, 1 = byte, 2 = half

  // Lane selection from the byte enables
  always_comb begin
    byte_s = raw[7:0];
    half_s = raw[15:0];
    kind_s = 2'd0;
    case (byte_en)
      BE_B0: begin byte_s = raw[7:0];   kind_s = 2'd1; end
      BE_B1: begin byte_s = raw[15:8];  kind_s = 2'd1; end
      BE_B2: begin byte_s = raw[23:16]; kind_s = 2'd1; end
      BE_B3: begin byte_s = raw[31:24]; kind_s = 2'd1; end
      BE_H0: begin half_s = raw[15:0];  kind_s = 2'd2; end
      BE_H1: begin half_s = raw[31:16]; kind_s = 2'd2; end
      default: kind_s = 2'd0;
    endcase
  end

  // Sign or zero extension of the selected lane
  always_comb begin
    case (kind_s)
      2'd1:    aligned = {{(BITS-8){load_signed & byte_s[7]}}, byte_s};
      2'd2:    aligned = {{(BITS-16){load_signed & half_s[15]}}, half_s};
      default: aligned = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined MIPS core: drives the data-memory handshake,
// stalls while an access is outstanding and implements the LL/SC link.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int BITS     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_s4,
  input  logic                sel_mem_s4,
  input  logic                mem_we_s4,
  input  logic                atomic_s4,
  input  logic                load_signed_s4,
  input  logic [BITS-1:0]     alu_out_s4,
  input  logic [BITS-1:0]     wdata_s4,
  input  logic [3:0]          byte_en_s4,
  mem_access_stage_if.master  dmem,
  output logic [BITS-1:0]     d_mem_rdata,
  output logic                link_rw_,
  output logic                stall_mem,
  output logic                mem_err
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [BITS-1:0] addr_q, addr_d;
  logic [BITS-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [BITS-1:0] rdata_q, rdata_d;
  logic            link_rw_q, link_rw_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            link_valid_q, link_valid_d;
  logic [BITS-3:0] link_addr_q, link_addr_d;
  logic            signed_q, signed_d;
  logic            atomic_q, atomic_d;

  logic            mem_access_s;
  logic            sc_s;
  logic            link_hit_s;
  logic            link_match_q_s;
  logic            timeout_s;
  logic [BITS-1:0] aligned_s;

  assign mem_access_s   = valid_s4 & sel_mem_s4;
  assign sc_s           = mem_access_s & mem_we_s4 & atomic_s4;
  assign link_hit_s     = link_valid_q & (link_addr_q == alu_out_s4[BITS-1:2]);
  assign link_match_q_s = link_valid_q & (link_addr_q == addr_q[BITS-1:2]);
  assign timeout_s      = (cnt_q == WAIT_LIMIT);

  load_align #(.BITS(BITS)) u_load_align (
    .raw         (dmem.d_mem_rdata_raw),
    .byte_en     (be_q),
    .load_signed (signed_q),
    .aligned     (aligned_s)
  );

  // Next-state and next-output computation for the access FSM
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    link_rw_d    = link_rw_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    signed_d     = signed_q;
    atomic_d     = atomic_q;

    case (state_q)
      IDLE: begin
        rdata_d   = {BITS{1'b0}};
        link_rw_d = READ_MODE;
        if (mem_access_s) begin
          if (sc_s) begin
            link_valid_d = 1'b0;
          end else begin
            link_valid_d = link_valid_q;
          end
          if (sc_s && !link_hit_s) begin
            state_d   = DONE;
            link_rw_d = 1'b0;
          end else begin
            state_d  = REQ;
            req_d    = 1'b1;
            we_d     = mem_we_s4;
            addr_d   = {alu_out_s4[BITS-1:2], 2'b00};
            wdata_d  = store_replicate(wdata_s4, byte_en_s4);
            be_d     = byte_en_s4;
            signed_d = load_signed_s4;
            atomic_d = atomic_s4;
            cnt_d    = {CW{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        if (dmem.d_mem_gnt && (we_q || dmem.d_mem_rvalid)) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (we_q && atomic_q) begin
            rdata_d   = {{(BITS-1){1'b0}}, 1'b1};
            link_rw_d = 1'b0;
          end else if (we_q) begin
            link_rw_d = READ_MODE;
            if (link_match_q_s) begin
              link_valid_d = 1'b0;
            end else begin
              link_valid_d = link_valid_q;
            end
          end else begin
            rdata_d   = aligned_s;
            link_rw_d = READ_MODE;
            if (atomic_q) begin
              link_valid_d = 1'b1;
              link_addr_d  = addr_q[BITS-1:2];
            end else begin
              link_valid_d = link_valid_q;
            end
          end
        end else if (timeout_s) begin
          state_d = ERR;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else if (dmem.d_mem_gnt) begin
          state_d = WAIT_R;
          req_d   = 1'b0;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_R: begin
        if (dmem.d_mem_rvalid) begin
          state_d   = DONE;
          rdata_d   = aligned_s;
          link_rw_d = READ_MODE;
          if (atomic_q) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr_q[BITS-1:2];
          end else begin
            link_valid_d = link_valid_q;
          end
        end else if (timeout_s) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d   = IDLE;
        rdata_d   = {BITS{1'b0}};
        link_rw_d = READ_MODE;
      end

      ERR: begin
        state_d = ERR;
        req_d   = 1'b0;
        err_d   = 1'b1;
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= {BITS{1'b0}};
      wdata_q      <= {BITS{1'b0}};
      be_q         <= BE_W;
      rdata_q      <= {BITS{1'b0}};
      link_rw_q    <= READ_MODE;
      err_q        <= 1'b0;
      cnt_q        <= {CW{1'b0}};
      link_valid_q <= 1'b0;
      link_addr_q  <= {(BITS-2){1'b0}};
      signed_q     <= 1'b0;
      atomic_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata_q      <= rdata_d;
      link_rw_q    <= link_rw_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      signed_q     <= signed_d;
      atomic_q     <= atomic_d;
    end
  end

  // Stall covers the issuing IDLE cycle so stage 4 holds before REQ is entered
  always_comb begin
    case (state_q)
      REQ, WAIT_R, ERR: stall_mem = 1'b1;
      IDLE:             stall_mem = mem_access_s;
      default:          stall_mem = 1'b0;
    endcase
  end

  assign dmem.d_mem_req   = req_q;
  assign dmem.d_mem_we    = we_q;
  assign dmem.d_mem_addr  = addr_q;
  assign dmem.d_mem_wdata = wdata_q;
  assign dmem.d_mem_be    = be_q;
  assign d_mem_rdata      = rdata_q;
  assign link_rw_         = link_rw_q;
  assign mem_err          = err_q;

endmodule
